multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RISC-V datapath (`yIF`/`yID`/`yEX`/`yDM`/`yWB`/`yPC`). It replaces hand-driven control: it steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the register-file, ALU, memory and PC-select controls. It waits on a data-memory acknowledge, and it counts retired instructions and stall cycles. It sits beside the datapath, takes `ins` and `zero` from it, and owns the PC register enable.

---
 rtl/ctrl_pkg.sv | 89 ++++++++
 rtl/multicycle_ctrl_if.sv | 40 ++++
 rtl/ctrl_decode.sv | 81 ++++++++
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - FSM state encoding (state_e)
//   - RISC-V opcode constants handled by the sequencer
//   - ALU op codes driven on `op`
//   - next-PC select codes driven on `pc_src`
//   - decoded instruction class and the bundle of registered control outputs
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_FETCH  = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_HALT   = 4'd7,
    S_TRAP   = 4'd8
  } state_e;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BEQ = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] PC_P4    = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  localparam logic [1:0] PC_ENTRY = 2'b11;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_JAL = 3'd5,
    CLS_BAD = 3'd6
  } ins_class_e;

  // Control outputs held in flops; one value per FSM state.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic [2:0] op;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       busy;
    logic       done;
    logic       trap;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    reg_write: 1'b0,
    alu_src:   1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    mem2reg:   1'b0,
    op:        ALU_ADD,
    pc_write:  1'b0,
    pc_src:    PC_P4,
    busy:      1'b0,
    done:      1'b0,
    trap:      1'b0
  };

  // Classes whose ALU B operand is the immediate.
  function automatic logic class_uses_imm(input ins_class_e cls);
    case (cls)
      CLS_I, CLS_LW, CLS_SW, CLS_JAL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the sequencer and the datapath / host.
//   master (sequencer): inputs start, ins, zero, mem_ack;
//                       outputs datapath controls, PC controls, status, counters
//   slave  (datapath/host): the mirror image
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [31:0]      ins;
  logic             zero;
  logic             mem_ack;
  logic             RegWrite;
  logic             ALUSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             Mem2Reg;
  logic [2:0]       op;
  logic             PCWrite;
  logic [1:0]       pc_src;
  logic             busy;
  logic             done;
  logic             trap;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] stalls;

  modport master (
    input  start, ins, zero, mem_ack,
    output RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op,
    output PCWrite, pc_src, busy, done, trap, retired, stalls
  );

  modport slave (
    output start, ins, zero, mem_ack,
    input  RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op,
    input  PCWrite, pc_src, busy, done, trap, retired, stalls
  );
endinterface

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Combinational instruction classifier.
//   opcode_i    : ins[6:0]
//   funct3_i    : ins[14:12]
//   funct7_b5_i : ins[30] (selects sub over add for R-type funct3 000)
//   cls_o       : instruction class
//   alu_op_o    : ALU op for R-type (sub for beq, add otherwise)
//   legal_o     : opcode supported and, for R-type, funct3 supported
// ---------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  output ins_class_e cls_o,
  output logic [2:0] alu_op_o,
  output logic       legal_o
);

  // Classify the opcode and pick the ALU operation.
  always_comb begin
    cls_o    = CLS_BAD;
    alu_op_o = ALU_ADD;
    legal_o  = 1'b0;
    case (opcode_i)
      OP_R: begin
        cls_o = CLS_R;
        case (funct3_i)
          3'b000: begin
            alu_op_o = funct7_b5_i ? ALU_SUB : ALU_ADD;
            legal_o  = 1'b1;
          end
          3'b110: begin
            alu_op_o = ALU_OR;
            legal_o  = 1'b1;
          end
          3'b111: begin
            alu_op_o = ALU_AND;
            legal_o  = 1'b1;
          end
          3'b010: begin
            alu_op_o = ALU_SLT;
            legal_o  = 1'b1;
          end
          default: begin
            alu_op_o = ALU_ADD;
            legal_o  = 1'b0;
          end
        endcase
      end
      OP_I: begin
        cls_o   = CLS_I;
        legal_o = 1'b1;
      end
      OP_LW: begin
        cls_o   = CLS_LW;
        legal_o = 1'b1;
      end
      OP_SW: begin
        cls_o   = CLS_SW;
        legal_o = 1'b1;
      end
      OP_BEQ: begin
        cls_o    = CLS_BEQ;
        alu_op_o = ALU_SUB;
        legal_o  = 1'b1;
      end
      OP_JAL: begin
        cls_o   = CLS_JAL;
        legal_o = 1'b1;
      end
      default: begin
        cls_o   = CLS_BAD;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath and PC controls, waits on
// the data-memory acknowledge and counts retired instructions and stalls.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : multicycle_ctrl_if.master (start/ins/zero/mem_ack in;
//                controls, status and counters out)
//   MAX_WAIT   : consecutive MEM cycles without mem_ack before trapping (>=1)
//   CNT_W      : width of the retired / stall counters
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [CNT_W-1:0]  stalls_q, stalls_d;

  ins_class_e cls_s;
  logic [2:0] alu_op_s;
  logic       legal_s;
  logic       beq_exec_s;
  logic       sw_ack_s;
  logic       pc_write_s;

  ctrl_decode u_decode (
    .opcode_i    (bus.ins[6:0]),
    .funct3_i    (bus.ins[14:12]),
    .funct7_b5_i (bus.ins[30]),
    .cls_o       (cls_s),
    .alu_op_o    (alu_op_s),
    .legal_o     (legal_s)
  );

  // Control outputs for a given state; ins is stable from the end of FETCH,
  // so class-dependent fields are valid whenever they are used.
  function automatic ctrl_t ctrl_for(input state_e st, input ins_class_e cls,
                                     input logic [2:0] alu_op);
    ctrl_t      c;
    logic [2:0] ex_op;
    logic       ex_src;
    c      = CTRL_RESET;
    ex_src = class_uses_imm(cls);
    ex_op  = (cls == CLS_R)   ? alu_op  :
             (cls == CLS_BEQ) ? ALU_SUB : ALU_ADD;
    case (st)
      S_IDLE: c = CTRL_RESET;
      S_LOAD: begin
        c.busy     = 1'b1;
        c.pc_write = 1'b1;
        c.pc_src   = PC_ENTRY;
      end
      S_FETCH, S_DECODE: c.busy = 1'b1;
      S_EXEC: begin
        c.busy    = 1'b1;
        c.alu_src = ex_src;
        c.op      = ex_op;
        if (cls == CLS_BEQ) begin
          // pc_src is resolved from zero at the output, not here.
          c.pc_write = 1'b1;
        end else if (cls == CLS_JAL) begin
          c.reg_write = 1'b1;
          c.pc_write  = 1'b1;
          c.pc_src    = PC_JMP;
        end else begin
          c.pc_write = 1'b0;
        end
      end
      S_MEM: begin
        c.busy      = 1'b1;
        c.alu_src   = 1'b1;
        c.op        = ALU_ADD;
        c.mem_read  = (cls == CLS_LW);
        c.mem_write = (cls == CLS_SW);
      end
      S_WB: begin
        c.busy      = 1'b1;
        c.reg_write = 1'b1;
        c.mem2reg   = (cls == CLS_LW);
        c.alu_src   = ex_src;
        c.op        = ex_op;
        c.pc_write  = 1'b1;
      end
      S_HALT:  c.done = 1'b1;
      S_TRAP:  c.trap = 1'b1;
      default: c.trap = 1'b1;
    endcase
    return c;
  endfunction

  // Next-state decode of the sequencer FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.start ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (bus.ins == 32'h0000_0000) begin
          state_d = S_HALT;
        end else if (!legal_s) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_s)
          CLS_R, CLS_I:     state_d = S_WB;
          CLS_LW, CLS_SW:   state_d = S_MEM;
          CLS_BEQ, CLS_JAL: state_d = S_FETCH;
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (bus.mem_ack) begin
          state_d = (cls_s == CLS_LW) ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Commit detection, wait counter and performance counter next values.
  always_comb begin
    beq_exec_s = (state_q == S_EXEC) && (cls_s == CLS_BEQ);
    // sw commits in the MEM cycle that sees the ack; no WB follows.
    sw_ack_s   = (state_q == S_MEM) && (cls_s == CLS_SW) && bus.mem_ack;
    pc_write_s = ctrl_q.pc_write | sw_ack_s;
    ctrl_d     = ctrl_for(state_d, cls_s, alu_op_s);

    if ((state_q == S_MEM) && !bus.mem_ack && (state_d == S_MEM)) begin
      wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_d = {WAIT_W{1'b0}};
    end

    // The entry-point load in LOAD is not an instruction commit.
    if (pc_write_s && (state_q != S_LOAD)) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end

    if ((state_q == S_MEM) && !bus.mem_ack) begin
      stalls_d = stalls_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stalls_d = stalls_q;
    end
  end

  // Sequencer state, registered controls and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= CTRL_RESET;
      wait_q    <= {WAIT_W{1'b0}};
      retired_q <= {CNT_W{1'b0}};
      stalls_q  <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      stalls_q  <= stalls_d;
    end
  end

  assign bus.RegWrite = ctrl_q.reg_write;
  assign bus.ALUSrc   = ctrl_q.alu_src;
  assign bus.MemRead  = ctrl_q.mem_read;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.Mem2Reg  = ctrl_q.mem2reg;
  assign bus.op       = ctrl_q.op;
  assign bus.PCWrite  = pc_write_s;
  assign bus.pc_src   = beq_exec_s ? (bus.zero ? PC_BR : PC_P4) : ctrl_q.pc_src;
  assign bus.busy     = ctrl_q.busy;
  assign bus.done     = ctrl_q.done;
  assign bus.trap     = ctrl_q.trap;
  assign bus.retired  = retired_q;
  assign bus.stalls   = stalls_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed stimulus; each cycle the stimulus pushes the hand-derived expected
// outputs for that cycle, and a negedge monitor pops and compares them.
// Control vector layout: {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
//                         op[2:0], PCWrite, pc_src[1:0], busy, done, trap}
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct {
    string       name;
    logic [13:0] ctl;
    bit          cc;
    logic [31:0] ret;
    logic [31:0] stl;
  } exp_t;

  localparam logic [13:0] C_IDLE = {5'b00000, 3'b010, 1'b0, 2'b00, 3'b000};
  localparam logic [13:0] C_LOAD = {5'b00000, 3'b010, 1'b1, 2'b11, 3'b100};
  localparam logic [13:0] C_BUSY = {5'b00000, 3'b010, 1'b0, 2'b00, 3'b100};
  localparam logic [13:0] C_HALT = {5'b00000, 3'b010, 1'b0, 2'b00, 3'b010};
  localparam logic [13:0] C_TRAP = {5'b00000, 3'b010, 1'b0, 2'b00, 3'b001};

  logic clk;
  logic reset;
  exp_t sbq[$];
  exp_t e;
  logic [13:0] act;
  int n_vec;
  int n_err;
  int unsigned exp_ret;
  int unsigned exp_stl;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.MAX_WAIT(8), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic rw, input logic as_,
      input logic mr, input logic mw, input logic m2r, input logic [2:0] op,
      input logic pcw, input logic [1:0] pcs, input logic bsy);
    return {rw, as_, mr, mw, m2r, op, pcw, pcs, bsy, 1'b0, 1'b0};
  endfunction

  // One clock: drive this cycle's inputs and queue this cycle's outputs.
  task automatic step(input logic [31:0] i, input logic z, input logic a,
      input logic s, input logic r, input string nm, input logic [13:0] ctl,
      input bit cc);
    @(posedge clk);
    #1;
    bus.ins = i; bus.zero = z; bus.mem_ack = a; bus.start = s; reset = r;
    sbq.push_back('{nm, ctl, cc, exp_ret, exp_stl});
  endtask

  task automatic run_alu(input logic [31:0] i, input logic src,
      input logic [2:0] op, input string nm);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_fetch"}, C_BUSY, 1'b1);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_decode"}, C_BUSY, 1'b0);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_exec"},
         mk(1'b0, src, 1'b0, 1'b0, 1'b0, op, 1'b0, 2'b00, 1'b1), 1'b0);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_wb"},
         mk(1'b1, src, 1'b0, 1'b0, 1'b0, op, 1'b1, 2'b00, 1'b1), 1'b1);
    exp_ret++;
  endtask

  task automatic run_mem(input logic [31:0] i, input logic lw, input int ns,
      input string nm);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_fetch"}, C_BUSY, 1'b1);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_decode"}, C_BUSY, 1'b0);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_exec"},
         mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1), 1'b0);
    for (int k = 0; k < ns; k++) begin
      step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_stall"},
           mk(1'b0, 1'b1, lw, ~lw, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1), 1'b1);
      exp_stl++;
    end
    if (lw) begin
      step(i, 1'b0, 1'b1, 1'b0, 1'b0, {nm, "_ack"},
           mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1), 1'b1);
      step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_wb"},
           mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 2'b00, 1'b1), 1'b1);
    end else begin
      step(i, 1'b0, 1'b1, 1'b0, 1'b0, {nm, "_ack"},
           mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 2'b00, 1'b1), 1'b1);
    end
    exp_ret++;
  endtask

  task automatic run_br(input logic [31:0] i, input logic z, input logic jal,
      input string nm);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_fetch"}, C_BUSY, 1'b1);
    step(i, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_decode"}, C_BUSY, 1'b0);
    if (jal) begin
      step(i, z, 1'b0, 1'b0, 1'b0, {nm, "_exec"},
           mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 2'b10, 1'b1), 1'b1);
    end else begin
      step(i, z, 1'b0, 1'b0, 1'b0, {nm, "_exec"},
           mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b1, {1'b0, z}, 1'b1), 1'b1);
    end
    exp_ret++;
  endtask

  // Assert reset in the current cycle (outputs still those of cur), then
  // start again: IDLE with start high, then LOAD.
  task automatic restart(input logic [13:0] cur, input string nm);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, {nm, "_at_reset"}, cur, 1'b1);
    exp_ret = 0;
    exp_stl = 0;
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, {nm, "_idle"}, C_IDLE, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_load"}, C_LOAD, 1'b1);
  endtask

  // Scoreboard monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_vec++;
      act = {bus.RegWrite, bus.ALUSrc, bus.MemRead, bus.MemWrite, bus.Mem2Reg,
             bus.op, bus.PCWrite, bus.pc_src, bus.busy, bus.done, bus.trap};
      if (act !== e.ctl ||
          (e.cc && (bus.retired !== e.ret || bus.stalls !== e.stl))) begin
        n_err++;
        $display("FAIL %s: got ctl=%b retired=%0d stalls=%0d, want ctl=%b retired=%0d stalls=%0d (counters %0s)",
                 e.name, act, bus.retired, bus.stalls, e.ctl, e.ret, e.stl,
                 e.cc ? "checked" : "ignored");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; exp_ret = 0; exp_stl = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.ins = 32'h0; bus.zero = 1'b0; bus.mem_ack = 1'b0;

    // Reset state, then start: LOAD one cycle later.
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_idle", C_IDLE, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "start_idle", C_IDLE, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "load", C_LOAD, 1'b1);

    run_alu(32'h00B50533, 1'b0, 3'b010, "add");
    run_alu(32'h40B50533, 1'b0, 3'b110, "sub");
    run_alu(32'h00B52533, 1'b0, 3'b011, "slt");
    run_alu(32'h00B56533, 1'b0, 3'b001, "or");
    run_alu(32'h00B57533, 1'b0, 3'b000, "and");
    run_alu(32'h00150513, 1'b1, 3'b010, "addi");
    run_mem(32'h0005A503, 1'b1, 2, "lw_s2");
    run_mem(32'h00A5A023, 1'b0, 0, "sw_s0");
    run_mem(32'h00A5A023, 1'b0, 1, "sw_s1");
    run_br(32'h00B50463, 1'b1, 1'b0, "beq_taken");
    run_br(32'h00B50463, 1'b0, 1'b0, "beq_not_taken");
    run_br(32'h008000EF, 1'b0, 1'b1, "jal");
    run_mem(32'h0005A503, 1'b1, 7, "lw_ack_last");

    // Memory never acknowledges: 8 MEM cycles, then TRAP without commit.
    step(32'h0005A503, 1'b0, 1'b0, 1'b0, 1'b0, "to_fetch", C_BUSY, 1'b1);
    step(32'h0005A503, 1'b0, 1'b0, 1'b0, 1'b0, "to_decode", C_BUSY, 1'b0);
    step(32'h0005A503, 1'b0, 1'b0, 1'b0, 1'b0, "to_exec",
         mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1), 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(32'h0005A503, 1'b0, 1'b0, 1'b0, 1'b0, "to_mem",
           mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1), 1'b1);
      exp_stl++;
    end
    step(32'h0005A503, 1'b0, 1'b1, 1'b1, 1'b0, "to_trap", C_TRAP, 1'b1);
    restart(C_TRAP, "to_restart");

    // Unsupported opcode traps straight out of DECODE.
    step(32'h0000007F, 1'b0, 1'b0, 1'b0, 1'b0, "op7f_fetch", C_BUSY, 1'b1);
    step(32'h0000007F, 1'b0, 1'b0, 1'b0, 1'b0, "op7f_decode", C_BUSY, 1'b1);
    restart(C_TRAP, "op7f_trap");

    // R-type with unsupported funct3 also traps in DECODE.
    step(32'h00B51533, 1'b0, 1'b0, 1'b0, 1'b0, "sll_fetch", C_BUSY, 1'b1);
    step(32'h00B51533, 1'b0, 1'b0, 1'b0, 1'b0, "sll_decode", C_BUSY, 1'b1);
    restart(C_TRAP, "sll_trap");

    // All-zero instruction halts; start in HALT has no effect.
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "halt_fetch", C_BUSY, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "halt_decode", C_BUSY, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "halt_start", C_HALT, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "halt_hold", C_HALT, 1'b1);
    restart(C_HALT, "halt");

    // Reset in the middle of a store's MEM wait.
    run_alu(32'h00B50533, 1'b0, 3'b010, "add2");
    step(32'h00A5A023, 1'b0, 1'b0, 1'b0, 1'b0, "rst_fetch", C_BUSY, 1'b1);
    step(32'h00A5A023, 1'b0, 1'b0, 1'b0, 1'b0, "rst_decode", C_BUSY, 1'b0);
    step(32'h00A5A023, 1'b0, 1'b0, 1'b0, 1'b0, "rst_exec",
         mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1), 1'b0);
    step(32'h00A5A023, 1'b0, 1'b0, 1'b0, 1'b1, "rst_mem",
         mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 2'b00, 1'b1), 1'b1);
    exp_ret = 0;
    exp_stl = 0;
    step(32'h00A5A023, 1'b0, 1'b0, 1'b0, 1'b0, "rst_idle", C_IDLE, 1'b1);
    step(32'h00A5A023, 1'b0, 1'b0, 1'b0, 1'b0, "rst_idle_hold", C_IDLE, 1'b1);

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected records left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
